operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Pipeline stage between instruction decode and execute.
- Drives the register bank read addresses (srcadd1/srcadd2) and captures the returned src1/src2 into a registered operand packet for the ALU.
- Keeps a 16-entry pending-write scoreboard and forwards writeback data.
- Stalls decode on RAW/WAW hazards; valid/ready handshake on both sides.

Parameters:
- DATA_W, 32, operand/register data width
- ADDR_W, 4, register address width (2^ADDR_W = 16 registers)
- OP_W, 6, opcode field width passed through to execute
- CNT_W, 16, stall performance counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction available
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  OP_W  opcode
- in_dest  in  ADDR_W  destination register
- in_wen  in  1  instruction writes in_dest
- in_rs1  in  ADDR_W  source register 1
- in_rs2  in  ADDR_W  source register 2
- in_use_imm  in  1  operand B comes from in_imm, rs2 ignored
- in_imm  in  DATA_W  immediate
- rb_srcadd1  out  ADDR_W  register bank read address 1
- rb_srcadd2  out  ADDR_W  register bank read address 2
- rb_src1  in  DATA_W  register bank read data 1 (combinational)
- rb_src2  in  DATA_W  register bank read data 2 (combinational)
- wb_valid  in  1  writeback this cycle
- wb_dest  in  ADDR_W  writeback register
- wb_data  in  DATA_W  writeback data
- out_valid  out  1  operand packet valid
- out_ready  in  1  execute accepts packet
- out_op  out  OP_W  registered opcode
- out_dest  out  ADDR_W  registered destination
- out_wen  out  1  registered write flag
- out_a  out  DATA_W  operand A
- out_b  out  DATA_W  operand B
- stall_count  out  CNT_W  cycles stalled on hazard

Behaviour:
- Reset (async, rst_n=0): out_valid=0; out_op/out_dest/out_wen/out_a/out_b=0; pending[15:0]=0; stall_count=0. Reset mid-operation drops the in-flight packet and clears all pending bits.
- rb_srcadd1=in_rs1, rb_srcadd2=in_rs2. Combinational, always driven.
- fwd1 = wb_valid && wb_dest==in_rs1. fwd2 is the same with in_rs2.
- hazard = (pending[in_rs1] && !fwd1) || (!in_use_imm && pending[in_rs2] && !fwd2) || (in_wen && pending[in_dest] && !(wb_valid && wb_dest==in_dest)).
- in_ready = (!out_valid || out_ready) && !hazard.
- accept = in_valid && in_ready. Latency is 1 cycle: the packet appears on out_* the cycle after accept.
- On accept:
  - out_a <= fwd1 ? wb_data : rb_src1
  - out_b <= in_use_imm ? in_imm : (fwd2 ? wb_data : rb_src2)
  - out_op/out_dest/out_wen <= inputs
  - out_valid <= 1
- If out_valid && out_ready && !accept: out_valid <= 0. Otherwise out_* hold while out_valid && !out_ready.
- Scoreboard:
  - wb_valid clears pending[wb_dest].
  - accept && in_wen sets pending[in_dest].
  - Same index set and cleared in one cycle: set wins.
  - Writeback to a non-pending register is legal and leaves pending unchanged.
- stall_count increments when in_valid && hazard. It saturates at 2^CNT_W-1.
- Back-pressure alone (out_valid && !out_ready) is not counted as a stall.
- No width conversion; all data paths are DATA_W wide.

Test Plan:
- Reset, rb_src1=10, rb_src2=115, accept rs1=0, rs2=15, in_wen=0 -> next cycle out_valid=1, out_a=10, out_b=115; pending stays 0.
- Accept wen=1 dest=3, then the next instruction reads rs1=3 with no writeback -> in_ready=0, stall_count counts 1,2,3. Then wb_valid=1, wb_dest=3, wb_data=13 -> accept in that cycle, out_a=13, pending[3]=0.
- in_use_imm=1, imm=0xDEADBEEF, rs2=5 pending -> no stall, out_b=0xDEADBEEF.
- out_ready=0 for 3 cycles with in_valid high -> out_* hold; in_ready=0; stall_count unchanged. Then out_ready=1 -> next packet accepted the same cycle.
- WAW: dest=7 pending, new instruction with dest=7 and wen=1 -> stall until wb_dest=7. Simultaneous wb_dest=7 and accept dest=7 -> pending[7]=1 afterwards.
- Assert rst_n=0 while out_valid=1 and pending=0x0088 -> out_valid=0 and pending=0 immediately, without a clock edge.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch stage with pending-write scoreboard, forwarding and hazard stall
module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_wen,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] rb_srcadd1,
    output logic [ADDR_W-1:0] rb_srcadd2,
    input  logic [DATA_W-1:0] rb_src1,
    input  logic [DATA_W-1:0] rb_src2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_wen,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int NREG = 1 << ADDR_W;

    // One bit per register: set while an accepted instruction has yet to write it back.
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    logic fwd1;
    logic fwd2;
    logic fwd_dest;
    logic hazard;
    logic accept;
    logic slot_free;

    assign rb_srcadd1 = in_rs1;
    assign rb_srcadd2 = in_rs2;

    // Hazard detection: a pending source or destination is only safe when the writeback lands this cycle.
    always_comb begin
        fwd1      = wb_valid && (wb_dest == in_rs1);
        fwd2      = wb_valid && (wb_dest == in_rs2);
        fwd_dest  = wb_valid && (wb_dest == in_dest);
        hazard    = (pending[in_rs1] && !fwd1)
                 || (!in_use_imm && pending[in_rs2] && !fwd2)
                 || (in_wen && pending[in_dest] && !fwd_dest);
        slot_free = !out_valid || out_ready;
        in_ready  = slot_free && !hazard;
        accept    = in_valid && in_ready;
    end

    // Scoreboard update: writeback clears first so a same-cycle set on the same index wins.
    always_comb begin
        pending_next = pending;
        if (wb_valid) begin
            pending_next[wb_dest] = 1'b0;
        end
        if (accept && in_wen) begin
            pending_next[in_dest] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Operand packet register: load on accept, drop when consumed with nothing behind it, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_dest  <= '0;
            out_wen   <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_dest  <= in_dest;
            out_wen   <= in_wen;
            out_a     <= fwd1 ? wb_data : rb_src1;
            out_b     <= in_use_imm ? in_imm : (fwd2 ? wb_data : rb_src2);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Hazard stall counter; back-pressure is not a hazard and is not counted. Saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (in_valid && hazard && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [3:0]  in_dest;
    logic        in_wen;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [3:0]  rb_srcadd1;
    logic [3:0]  rb_srcadd2;
    logic [31:0] rb_src1;
    logic [31:0] rb_src2;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_op;
    logic [3:0]  out_dest;
    logic        out_wen;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    operand_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_dest     (in_dest),
        .in_wen      (in_wen),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_use_imm  (in_use_imm),
        .in_imm      (in_imm),
        .rb_srcadd1  (rb_srcadd1),
        .rb_srcadd2  (rb_srcadd2),
        .rb_src1     (rb_src1),
        .rb_src2     (rb_src2),
        .wb_valid    (wb_valid),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_dest    (out_dest),
        .out_wen     (out_wen),
        .out_a       (out_a),
        .out_b       (out_b),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [3:0] dest, input logic wen,
                             input logic [3:0] rs1, input logic [3:0] rs2);
        in_op  = op;
        in_dest = dest;
        in_wen = wen;
        in_rs1 = rs1;
        in_rs2 = rs2;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        set_instr(6'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        in_use_imm = 1'b0;
        in_imm = '0;
        rb_src1 = '0;
        rb_src2 = '0;
        wb_valid = 1'b0;
        wb_dest = '0;
        wb_data = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_a", out_a, 0);
        check("rst_stall", stall_count, 0);
        check("rst_pending", dut.pending, 0);
        step();
        step();
        rst_n = 1'b1;

        // Plain accept, no hazards
        rb_src1 = 32'd10;
        rb_src2 = 32'd115;
        in_valid = 1'b1;
        set_instr(6'd5, 4'd0, 1'b0, 4'd0, 4'd15);
        #1;
        check("t1_in_ready", in_ready, 1);
        check("t1_srcadd1", rb_srcadd1, 0);
        check("t1_srcadd2", rb_srcadd2, 15);
        step();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_a", out_a, 10);
        check("t1_out_b", out_b, 115);
        check("t1_out_op", out_op, 5);
        check("t1_pending", dut.pending, 0);

        // RAW stall on r3, released by same-cycle writeback forward
        rb_src1 = 32'd20;
        rb_src2 = 32'd30;
        set_instr(6'd1, 4'd3, 1'b1, 4'd1, 4'd2);
        step();
        check("t2_out_a", out_a, 20);
        check("t2_out_dest", out_dest, 3);
        check("t2_out_wen", out_wen, 1);
        check("t2_pending", dut.pending, 16'h0008);
        set_instr(6'd2, 4'd0, 1'b0, 4'd3, 4'd0);
        #1;
        check("t2_in_ready_stall", in_ready, 0);
        step();
        check("t2_stall1", stall_count, 1);
        check("t2_drained", out_valid, 0);
        step();
        check("t2_stall2", stall_count, 2);
        step();
        check("t2_stall3", stall_count, 3);
        wb_valid = 1'b1;
        wb_dest = 4'd3;
        wb_data = 32'd13;
        #1;
        check("t2_in_ready_fwd", in_ready, 1);
        step();
        check("t2_fwd_out_a", out_a, 13);
        check("t2_fwd_pending", dut.pending, 0);
        check("t2_stall_hold", stall_count, 3);
        wb_valid = 1'b0;

        // Immediate operand ignores pending rs2
        set_instr(6'd3, 4'd5, 1'b1, 4'd0, 4'd0);
        step();
        check("t3_pending", dut.pending, 16'h0020);
        in_use_imm = 1'b1;
        in_imm = 32'hDEADBEEF;
        set_instr(6'd4, 4'd0, 1'b0, 4'd0, 4'd5);
        #1;
        check("t3_in_ready", in_ready, 1);
        step();
        check("t3_out_b", out_b, 32'hDEADBEEF);
        check("t3_stall", stall_count, 3);
        in_use_imm = 1'b0;

        // Back-pressure holds the packet without counting stalls
        out_ready = 1'b0;
        rb_src1 = 32'h111;
        set_instr(6'd6, 4'd0, 1'b0, 4'd1, 4'd2);
        #1;
        check("t4_in_ready_bp", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_b", out_b, 32'hDEADBEEF);
            check("t4_hold_op", out_op, 4);
            check("t4_stall", stall_count, 3);
        end
        out_ready = 1'b1;
        #1;
        check("t4_in_ready_rel", in_ready, 1);
        step();
        check("t4_out_a", out_a, 32'h111);
        check("t4_out_op", out_op, 6);

        // WAW on r7, then simultaneous writeback and re-set
        set_instr(6'd7, 4'd7, 1'b1, 4'd0, 4'd0);
        step();
        check("t5_pending", dut.pending, 16'h00A0);
        set_instr(6'd8, 4'd7, 1'b1, 4'd0, 4'd0);
        #1;
        check("t5_in_ready_waw", in_ready, 0);
        step();
        check("t5_stall", stall_count, 4);
        wb_valid = 1'b1;
        wb_dest = 4'd7;
        wb_data = 32'h77;
        #1;
        check("t5_in_ready_wb", in_ready, 1);
        step();
        check("t5_set_wins", dut.pending, 16'h00A0);
        check("t5_out_op", out_op, 8);
        in_valid = 1'b0;
        wb_dest = 4'd2;
        step();
        check("t5_wb_nonpending", dut.pending, 16'h00A0);
        check("t5_drained", out_valid, 0);
        wb_dest = 4'd5;
        step();
        check("t5_clear5", dut.pending, 16'h0080);
        wb_valid = 1'b0;

        // Asynchronous reset with a packet in flight
        in_valid = 1'b1;
        set_instr(6'd9, 4'd3, 1'b1, 4'd0, 4'd0);
        step();
        in_valid = 1'b0;
        check("t6_pre_pending", dut.pending, 16'h0088);
        check("t6_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_pending", dut.pending, 0);
        check("t6_async_stall", stall_count, 0);
        check("t6_async_out_a", out_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
